// File: rtl/puf_pkg.sv
// Shared types and LFSR helpers for the PUF response collector.
// The state enum, default feedback taps and the challenge-stepping function live here.
package puf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [63:0] TAPS_DEFAULT = 64'hD800000000000000;

  // An all-zero LFSR never leaves zero, so a zero seed is replaced by this.
  localparam logic [63:0] SEED_SUB = 64'h1;

  function automatic logic [63:0] lfsr_next(
    input logic [63:0] c,
    input logic [63:0] taps
  );
    return {c[62:0], ^(c & taps)};
  endfunction

endpackage

// File: rtl/puf_challenge_lfsr.sv
// Challenge generator: a Fibonacci LFSR seeded per request.
// A zero seed is swapped for a nonzero constant so the sequence never locks up.
module puf_challenge_lfsr
  import puf_pkg::*;
#(
  parameter int          CW   = 64,
  parameter logic [CW-1:0] TAPS = CW'(TAPS_DEFAULT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] seed,
  input  logic          step,
  output logic [CW-1:0] state
);

  logic [63:0] nxt;

  assign nxt = lfsr_next(64'(state), 64'(TAPS));

  // Load wins over step; both are idle outside a request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= '0;
    end else if (load) begin
      state <= (seed == '0) ? SEED_SUB[CW-1:0] : seed;
    end else if (step) begin
      state <= nxt[CW-1:0];
    end
  end

endmodule

// File: rtl/puf_response_collector.sv
// Multi-bit response engine for a single-bit arbiter PUF core.
// Each response bit is the majority of VOTES settled samples of one sub-challenge.
module puf_response_collector
  import puf_pkg::*;
#(
  parameter int            CW     = 64,
  parameter int            RW     = 8,
  parameter int            VOTES  = 3,
  parameter int            SETTLE = 2,
  parameter logic [CW-1:0] TAPS   = CW'(TAPS_DEFAULT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [CW-1:0] req_seed,
  output logic [CW-1:0] puf_challenge,
  input  logic          puf_response,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [RW-1:0] rsp_data,
  output logic [RW-1:0] rsp_unstable,
  output logic          busy
);

  localparam int IW = (RW > 1) ? $clog2(RW) : 1;
  localparam int VW = $clog2(VOTES + 1);
  localparam int SW = $clog2(SETTLE + 1);

  state_t        st;
  logic [IW-1:0] bit_idx;
  logic [VW-1:0] vote_cnt;
  logic [VW-1:0] ones;
  logic [VW-1:0] ones_nxt;
  logic [SW-1:0] settle_cnt;
  logic [CW-1:0] lfsr_q;
  logic          accept;
  logic          last_vote;
  logic          last_bit;
  logic          lfsr_step;

  assign accept    = (st == IDLE) && req_valid;
  assign last_vote = (vote_cnt == VW'(VOTES - 1));
  assign last_bit  = (bit_idx == IW'(RW - 1));
  assign ones_nxt  = ones + VW'(puf_response);

  // The final sub-challenge is not stepped past, so DONE keeps showing it.
  assign lfsr_step = (st == SAMPLE) && last_vote && !last_bit;

  assign req_ready     = (st == IDLE);
  assign busy          = (st != IDLE);
  assign puf_challenge = (st == IDLE) ? '0 : lfsr_q;

  puf_challenge_lfsr #(
    .CW   (CW),
    .TAPS (TAPS)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .seed  (req_seed),
    .step  (lfsr_step),
    .state (lfsr_q)
  );

  // Sequencer: settle, sample, vote, then publish one bit per sub-challenge.
  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= IDLE;
      bit_idx      <= '0;
      vote_cnt     <= '0;
      ones         <= '0;
      settle_cnt   <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_unstable <= '0;
    end else begin
      unique case (st)
        IDLE: begin
          if (req_valid) begin
            st         <= APPLY;
            bit_idx    <= '0;
            vote_cnt   <= '0;
            ones       <= '0;
            settle_cnt <= '0;
          end
        end
        APPLY: begin
          if (settle_cnt == SW'(SETTLE - 1)) begin
            settle_cnt <= '0;
            st         <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        SAMPLE: begin
          if (!last_vote) begin
            vote_cnt <= vote_cnt + 1'b1;
            ones     <= ones_nxt;
            st       <= APPLY;
          end else begin
            rsp_data[bit_idx]     <= (ones_nxt > VW'(VOTES / 2));
            rsp_unstable[bit_idx] <= (ones_nxt != '0)
                                  && (ones_nxt != VW'(VOTES));
            vote_cnt <= '0;
            ones     <= '0;
            if (last_bit) begin
              bit_idx   <= '0;
              rsp_valid <= 1'b1;
              st        <= DONE;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              st      <= APPLY;
            end
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            st        <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_response_collector.sv
// Randomized bench for puf_response_collector.
// Expected responses come from a per-bit vote model of the LFSR sequence.
module tb_puf_response_collector;

  localparam int CW       = 64;
  localparam int RW       = 8;
  localparam int VOTES    = 3;
  localparam int SETTLE   = 2;
  localparam int PER_VOTE = SETTLE + 1;
  localparam int PER_BIT  = VOTES * PER_VOTE;
  localparam int LAT      = RW * PER_BIT;
  localparam logic [63:0] TAPS = 64'hD800000000000000;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [CW-1:0] req_seed;
  logic [CW-1:0] puf_challenge;
  logic          puf_response;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [RW-1:0] rsp_data;
  logic [RW-1:0] rsp_unstable;
  logic          busy;
  logic          noise;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0]   exp_chal [RW];
  logic [63:0]   obs_chal [RW];
  logic [RW-1:0] exp_data;
  logic [RW-1:0] exp_uns;
  logic [RW-1:0] stable_data;

  assign puf_response = (^puf_challenge) ^ noise;

  always #5 clk = ~clk;

  puf_response_collector dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_seed      (req_seed),
    .puf_challenge (puf_challenge),
    .puf_response  (puf_response),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_unstable  (rsp_unstable),
    .busy          (busy)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mstep(input logic [63:0] c);
    return {c[62:0], ^(c & TAPS)};
  endfunction

  // Model: bit i sees challenge c_i for VOTES samples, flip marks inverted votes.
  task automatic build_model(
    input logic [63:0]          seed,
    input logic [RW*VOTES-1:0]  flip
  );
    logic [63:0] c;
    int ones;
    c = (seed == 64'h0) ? 64'h1 : seed;
    for (int i = 0; i < RW; i++) begin
      exp_chal[i] = c;
      ones = 0;
      for (int v = 0; v < VOTES; v++)
        ones += ((^c) ^ flip[i*VOTES+v]) ? 1 : 0;
      exp_data[i] = (ones > VOTES / 2);
      exp_uns[i]  = (ones != 0) && (ones != VOTES);
      c = mstep(c);
    end
  endtask

  task automatic do_req(
    input logic [63:0]         seed,
    input logic [RW*VOTES-1:0] flip
  );
    build_model(seed, flip);
    chk("req_ready_pre", 64'(req_ready), 64'h1);
    req_seed  = seed;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      noise = flip[k / PER_VOTE];
      if (k % PER_BIT == 0) obs_chal[k / PER_BIT] = puf_challenge;
      chk("chal", puf_challenge, exp_chal[k / PER_BIT]);
      chk("busy", 64'(busy), 64'h1);
      chk("early_vld", 64'(rsp_valid), 64'h0);
      req_valid = 1'($urandom);
      req_seed  = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    noise     = 1'b0;
    req_valid = 1'b0;
    chk("rsp_valid", 64'(rsp_valid), 64'h1);
    chk("rsp_data", 64'(rsp_data), 64'(exp_data));
    chk("rsp_uns", 64'(rsp_unstable), 64'(exp_uns));
    chk("done_chal", puf_challenge, exp_chal[RW-1]);
  endtask

  task automatic ack(input int hold);
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      chk("bp_vld", 64'(rsp_valid), 64'h1);
      chk("bp_data", 64'(rsp_data), 64'(exp_data));
      chk("bp_uns", 64'(rsp_unstable), 64'(exp_uns));
      chk("bp_chal", puf_challenge, exp_chal[RW-1]);
      chk("bp_rdy", 64'(req_ready), 64'h0);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_seed  = {$urandom, $urandom};
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("ack_vld", 64'(rsp_valid), 64'h0);
    chk("ack_rdy", 64'(req_ready), 64'h1);
    chk("ack_busy", 64'(busy), 64'h0);
    chk("ack_chal", puf_challenge, 64'h0);
    chk("ack_data", 64'(rsp_data), 64'(exp_data));
  endtask

  initial begin
    logic seen;
    logic [RW*VOTES-1:0] fl;
    rst       = 1'b1;
    req_valid = 1'b1;
    req_seed  = 64'hDEADBEEF;
    rsp_ready = 1'b0;
    noise     = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_rdy", 64'(req_ready), 64'h1);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_vld", 64'(rsp_valid), 64'h0);
      chk("rst_chal", puf_challenge, 64'h0);
      chk("rst_data", 64'(rsp_data), 64'h0);
      chk("rst_uns", 64'(rsp_unstable), 64'h0);
    end
    rst       = 1'b0;
    req_valid = 1'b0;
    @(posedge clk); #1;

    do_req(64'hA5A5A5A5A5A5A5A5, '0);
    chk("stable_bit0", 64'(rsp_data[0]), 64'h0);
    chk("stable_uns", 64'(rsp_unstable), 64'h0);
    stable_data = rsp_data;
    ack(10);

    fl = '0;
    fl[3*VOTES+1] = 1'b1;
    do_req(64'hA5A5A5A5A5A5A5A5, fl);
    chk("noisy_data", 64'(rsp_data), 64'(stable_data));
    chk("noisy_uns", 64'(rsp_unstable), 64'h08);
    ack(2);

    do_req(64'h0, '0);
    chk("zero_c0", obs_chal[0], 64'h1);
    chk("zero_c1", obs_chal[1], 64'h2);
    ack(0);

    for (int r = 0; r < 6; r++) begin
      fl = RW*VOTES'($urandom & $urandom & $urandom);
      do_req({$urandom, $urandom}, fl);
      ack($urandom_range(0, 3));
    end

    req_seed  = 64'h0123456789ABCDEF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_chal", puf_challenge, 64'h0);
    chk("mid_busy", 64'(busy), 64'h0);
    chk("mid_rdy", 64'(req_ready), 64'h1);
    for (int k = 0; k < LAT + 10; k++) begin
      if (rsp_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("mid_no_rsp", 64'(seen), 64'h0);

    do_req(64'h0123456789ABCDEF, '0);
    ack(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
